// File: rtl/cdc_event_sched.sv
// cdc_event_sched: shares one single-bit toggle CDC path between N_REQ
// event requesters. Pending events are granted round-robin. Each grant
// flips o_toggle and then waits for the synchronized acknowledge toggle to
// match it. A watchdog parks the block in ERR if the handshake is lost.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no transfer in flight; grant the next pending requester
// S_SETUP | o_id is stable; flip o_toggle on exit
// S_WAIT  | waiting for i_ack_sync == o_toggle; watchdog counting
// S_ERR   | handshake lost; hold until i_clr_err with ack re-aligned
module cdc_event_sched #(
  parameter int  N_REQ       = 4,
  parameter int  TIMEOUT_CYC = 1023,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_ack_sync,
  input  logic             i_clr_err,
  output logic             o_toggle,
  output logic [ID_W-1:0]  o_id,
  output logic [N_REQ-1:0] o_pend,
  output logic [N_REQ-1:0] o_done,
  output logic             o_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_ERR} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] last, last_nxt;
  logic [ID_W-1:0] id_nxt;
  logic            toggle_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [N_REQ-1:0] clr_vec, done_vec;
  logic            timeout_evt;
  logic            ack_match;

  logic            found_hi, found_lo;
  logic [ID_W-1:0] idx_hi, idx_lo, grant_idx;

  assign ack_match = (i_ack_sync == o_toggle);

  // Round-robin search: first pending index above `last`, else the lowest pending index.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found_hi && o_pend[i] && (i > int'(last))) begin
        found_hi = 1'b1;
        idx_hi   = ID_W'(i);
      end
      if (!found_lo && o_pend[i]) begin
        found_lo = 1'b1;
        idx_lo   = ID_W'(i);
      end
    end
    grant_idx = found_hi ? idx_hi : idx_lo;
  end

  // Next-state logic, handshake decisions and watchdog.
  always_comb begin
    state_nxt   = state;
    toggle_nxt  = o_toggle;
    id_nxt      = o_id;
    last_nxt    = last;
    timer_nxt   = timer;
    clr_vec     = '0;
    done_vec    = '0;
    timeout_evt = 1'b0;
    case (state)
      S_IDLE: begin
        if (|o_pend) begin
          id_nxt    = grant_idx;
          last_nxt  = grant_idx;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        toggle_nxt = ~o_toggle;
        timer_nxt  = '0;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (ack_match) begin
          done_vec  = N_REQ'(1) << o_id;
          clr_vec   = N_REQ'(1) << o_id;
          state_nxt = S_IDLE;
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          timeout_evt = 1'b1;
          clr_vec     = N_REQ'(1) << o_id;
          state_nxt   = S_ERR;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_ERR: begin
        if (i_clr_err && ack_match) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath registers; a new request beats a same-cycle clear, a timeout beats a same-cycle error clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_toggle  <= 1'b0;
      o_id      <= '0;
      last      <= ID_W'(N_REQ - 1);
      timer     <= '0;
      o_pend    <= '0;
      o_done    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_toggle <= toggle_nxt;
      o_id     <= id_nxt;
      last     <= last_nxt;
      timer    <= timer_nxt;
      o_pend   <= (o_pend & ~clr_vec) | i_req;
      o_done   <= done_vec;
      if (timeout_evt)    o_timeout <= 1'b1;
      else if (i_clr_err) o_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_event_sched.sv
// Bench for cdc_event_sched: N_REQ=4, TIMEOUT_CYC=8, ack looped back from
// o_toggle through a 3-stage delay that can be disconnected. Expected
// o_done pulses (vector, toggle level, cycle) go into a queue that a
// separate monitor pops.
module tb_cdc_event_sched;

  logic       clk;
  logic       rst;
  logic [3:0] i_req;
  logic       i_clr_err;
  logic       ack_w;
  logic       o_toggle;
  logic [1:0] o_id;
  logic [3:0] o_pend;
  logic [3:0] o_done;
  logic       o_timeout;

  logic       loop_en;
  logic       ack_hold;
  logic [2:0] ack_sh;
  int         cyc;
  int         checks;
  int         errors;
  int         c0;

  typedef struct {
    logic [3:0] done;
    logic       tog;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  cdc_event_sched #(.N_REQ(4), .TIMEOUT_CYC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_ack_sync (ack_w),
    .i_clr_err  (i_clr_err),
    .o_toggle   (o_toggle),
    .o_id       (o_id),
    .o_pend     (o_pend),
    .o_done     (o_done),
    .o_timeout  (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Destination-side loopback, reset together with the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) ack_sh <= '0;
    else     ack_sh <= {ack_sh[1:0], o_toggle};
  end
  assign ack_w = loop_en ? ack_sh[2] : ack_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] d, input logic t, input int c);
    exp_t x;
    x.done = d;
    x.tog  = t;
    x.cyc  = c;
    q.push_back(x);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 32'(q.size()), 0);
  endtask

  // Monitor: every o_done pulse must match the next expected transfer.
  always @(negedge clk) begin
    if (!rst && o_done != 4'b0000) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'(o_done), 0);
      end else begin
        e = q.pop_front();
        check("done_vec", 32'(o_done), 32'(e.done));
        check("done_toggle", 32'(o_toggle), 32'(e.tog));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1; i_req = '0; i_clr_err = 1'b0;
    loop_en = 1'b1; ack_hold = 1'b0;
    step(2);
    check("rst_toggle", 32'(o_toggle), 0);
    check("rst_id", 32'(o_id), 0);
    check("rst_pend", 32'(o_pend), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_timeout", 32'(o_timeout), 0);
    rst = 1'b0;
    step(1);

    // Single event, no contention.
    c0 = cyc; i_req = 4'b0001; push(4'b0001, 1'b1, c0 + 7);
    step(1); i_req = '0;
    check("t1_pend_set", 32'(o_pend), 4'b0001);
    step(1);
    check("t1_id", 32'(o_id), 0);
    check("t1_toggle_before", 32'(o_toggle), 0);
    step(1);
    check("t1_toggle_after", 32'(o_toggle), 1);
    drain(20);
    step(2);
    check("t1_pend_clear", 32'(o_pend), 0);

    // Round-robin contention from reset.
    rst = 1'b1; step(2); rst = 1'b0; step(1);
    c0 = cyc; i_req = 4'b1111;
    push(4'b0001, 1'b1, c0 + 7);
    push(4'b0010, 1'b0, c0 + 13);
    push(4'b0100, 1'b1, c0 + 19);
    push(4'b1000, 1'b0, c0 + 25);
    step(1); i_req = '0;
    check("t2_pend_all", 32'(o_pend), 4'b1111);
    step(1);
    check("t2_first_id", 32'(o_id), 0);
    drain(60);

    // Fairness after a wrap: 3 before 0 once 2 was granted.
    c0 = cyc; i_req = 4'b0100;
    push(4'b0100, 1'b1, c0 + 7);
    push(4'b1000, 1'b0, c0 + 13);
    push(4'b0001, 1'b1, c0 + 19);
    step(1); i_req = '0;
    step(2); i_req = 4'b1001;
    step(1); i_req = '0;
    drain(60);

    // Coalescing and set-wins on the done edge.
    c0 = cyc; i_req = 4'b0010;
    push(4'b0010, 1'b0, c0 + 7);
    push(4'b0010, 1'b1, c0 + 13);
    step(1); i_req = '0;
    step(1); i_req = 4'b0010;
    step(1); i_req = '0;
    step(1); i_req = 4'b0010;
    step(1); i_req = '0;
    step(1); i_req = 4'b0010;
    step(1); i_req = '0;
    check("t4_pend_set_wins", 32'(o_pend), 4'b0010);
    drain(40);
    step(3);
    check("t4_pend_clear", 32'(o_pend), 0);

    // Watchdog with the ack loop disconnected.
    ack_hold = ack_sh[2]; loop_en = 1'b0;
    c0 = cyc; i_req = 4'b0001;
    step(1); i_req = '0;
    step(1);
    check("t5_id", 32'(o_id), 0);
    step(1);
    check("t5_toggle", 32'(o_toggle), 0);
    step(7);
    check("t5_timeout_early", 32'(o_timeout), 0);
    step(1);
    check("t5_timeout_set", 32'(o_timeout), 1);
    check("t5_pend_dropped", 32'(o_pend), 0);
    i_req = 4'b0100;
    step(1); i_req = '0; i_clr_err = 1'b1;
    step(1); i_clr_err = 1'b0;
    check("t5_req_latched", 32'(o_pend), 4'b0100);
    check("t5_timeout_cleared", 32'(o_timeout), 0);
    step(4);
    check("t5_err_hold_id", 32'(o_id), 0);
    check("t5_err_hold_toggle", 32'(o_toggle), 0);
    loop_en = 1'b1; i_clr_err = 1'b1;
    c0 = cyc; push(4'b0100, 1'b1, c0 + 7);
    step(1); i_clr_err = 1'b0;
    drain(40);

    // Async reset mid-transfer.
    c0 = cyc; i_req = 4'b1010; push(4'b1000, 1'b0, c0 + 7);
    step(1); i_req = '0;
    step(7); i_req = 4'b0001;
    step(1); i_req = '0;
    step(1);
    check("t6_pre_toggle", 32'(o_toggle), 1);
    check("t6_pre_id", 32'(o_id), 1);
    check("t6_pre_pend", 32'(o_pend), 4'b0011);
    #1 rst = 1'b1;
    #1;
    check("t6_async_toggle", 32'(o_toggle), 0);
    check("t6_async_id", 32'(o_id), 0);
    check("t6_async_pend", 32'(o_pend), 0);
    check("t6_async_done", 32'(o_done), 0);
    check("t6_async_timeout", 32'(o_timeout), 0);
    step(2); rst = 1'b0;
    step(1);
    c0 = cyc; i_req = 4'b0100; push(4'b0100, 1'b1, c0 + 7);
    step(1); i_req = '0;
    step(1);
    check("t6_id", 32'(o_id), 2);
    check("t6_toggle_before", 32'(o_toggle), 0);
    step(1);
    check("t6_toggle_after", 32'(o_toggle), 1);
    drain(40);
    step(3);
    check("t6_pend_clear", 32'(o_pend), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
